// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: controller state and per-stage control pair.
// Pure definitions; no latency or flow-control behaviour of its own.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctl_s;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible one clk after inc_i; holds at all-ones, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe; zero-cycle combinational reaction to inputs.
// Priority mem_busy > branch > bubble; STALL_PERF_CNT_EN adds stall/flush cycle counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int BR_SHADOW  = 2,
  parameter int MAX_BUBBLE = 8,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       bubble_i,
  input  logic       branch_taken_i,
  input  logic       mem_busy_i,
  output logic       pc_en_o,
  output logic       fd_en_o,
  output logic       dx_en_o,
  output logic       xm_en_o,
  output logic       mw_en_o,
  output logic       fd_flush_o,
  output logic       dx_flush_o,
  output logic       xm_flush_o,
  output logic       hazard_err_o,
  output logic [1:0] state_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cyc_o,
  output logic [CNT_W-1:0] flush_cyc_o
`endif
);

  localparam int SH_W = (BR_SHADOW > 1) ? $clog2(BR_SHADOW) : 1;
  localparam int BW   = $clog2(MAX_BUBBLE);

  ctrl_state_e state_q, state_d;
  logic [SH_W-1:0] shadow_q, shadow_d;
  logic br_pend_q, br_pend_d;
  logic err_q, err_d;
  logic release_q, release_d;
  logic active_q;
  logic pc_en, mw_en, bub_stall, trip;
  stage_ctl_s fd_c, dx_c, xm_c;
  logic [BW-1:0] bub_cnt;

  // Holds every enable low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= RUN;
      shadow_q  <= '0;
      br_pend_q <= 1'b0;
      err_q     <= 1'b0;
      release_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      br_pend_q <= br_pend_d;
      err_q     <= err_d;
      release_q <= release_d;
      active_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    br_pend_d = br_pend_q;
    err_d     = err_q;
    release_d = 1'b0;
    pc_en     = 1'b0;
    mw_en     = 1'b0;
    fd_c      = '0;
    dx_c      = '0;
    xm_c      = '0;
    bub_stall = 1'b0;
    trip      = 1'b0;
    if (active_q) begin
      if (mem_busy_i) begin
        state_d = MEM_WAIT;
        if (branch_taken_i) br_pend_d = 1'b1;
      end else if (branch_taken_i || br_pend_q) begin
        {pc_en, fd_c.en, dx_c.en, xm_c.en, mw_en} = '1;
        fd_c.flush = 1'b1;
        dx_c.flush = 1'b1;
        br_pend_d  = 1'b0;
        shadow_d   = SH_W'(BR_SHADOW - 1);
        state_d    = (BR_SHADOW > 1) ? BR_FLUSH : RUN;
      end else if (state_q == BR_FLUSH) begin
        // The shadow instruction is already dead, so a bubble request here is moot.
        {pc_en, fd_c.en, dx_c.en, xm_c.en, mw_en} = '1;
        fd_c.flush = 1'b1;
        shadow_d   = shadow_q - 1'b1;
        if (shadow_q == SH_W'(1)) state_d = RUN;
      end else if (bubble_i && !release_q) begin
        xm_c.en    = 1'b1;
        mw_en      = 1'b1;
        xm_c.flush = 1'b1;
        bub_stall  = 1'b1;
        state_d    = RUN;
        if (bub_cnt == BW'(MAX_BUBBLE - 1)) begin
          trip      = 1'b1;
          err_d     = 1'b1;
          release_d = 1'b1;
        end
      end else begin
        {pc_en, fd_c.en, dx_c.en, xm_c.en, mw_en} = '1;
        state_d = RUN;
      end
    end
  end

  sat_counter #(.W(BW)) u_bub_cnt (
    .clk     (clk),
    .n_reset (n_reset),
    .clr_i   (!bub_stall || trip),
    .inc_i   (bub_stall),
    .cnt_o   (bub_cnt)
  );

  assign pc_en_o      = pc_en;
  assign fd_en_o      = fd_c.en;
  assign dx_en_o      = dx_c.en;
  assign xm_en_o      = xm_c.en;
  assign mw_en_o      = mw_en;
  assign fd_flush_o   = fd_c.flush;
  assign dx_flush_o   = dx_c.flush;
  assign xm_flush_o   = xm_c.flush;
  assign hazard_err_o = err_q;
  assign state_o      = state_q;

`ifdef STALL_PERF_CNT_EN
  // Bubble insertion already shows up as stall cycles; flush cycles track branch kills only.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .n_reset (n_reset),
    .clr_i   (1'b0),
    .inc_i   (active_q && !pc_en),
    .cnt_o   (stall_cyc_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .n_reset (n_reset),
    .clr_i   (1'b0),
    .inc_i   (fd_c.flush || dx_c.flush),
    .cnt_o   (flush_cyc_o)
  );
`endif

endmodule
